dispatch_queue: RTL and testbench
=================================

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 SHALL have parameter BWIDTH, default 57: instruction bundle width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of queue entries; only powers of two from 4 to 64 are legal.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_flush, input, 1 bit: discard all entries.
REQ-006 SHALL have ports i_enq_bundle0 and i_enq_bundle1, input, BWIDTH bits each: bundles from decode, in program order.
REQ-007 SHALL have port i_enq_valid, input, 2 bits: bit k qualifies i_enq_bundlek.
REQ-008 SHALL have port o_enq_ready, output, 2 bits: bit k means at least k+1 entries are free.
REQ-009 SHALL have ports o_ins_bundle0 through o_ins_bundle3, output, BWIDTH bits each: the oldest four entries in order, toward the reservation station.
REQ-010 SHALL have port o_ins_valid, output, 4 bits: bit k qualifies o_ins_bundlek.
REQ-011 SHALL have port i_disp_accept, input, 4 bits: per-slot acceptance from the reservation station.
REQ-012 SHALL have port o_count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have ports o_empty and o_full, output, 1 bit each: occupancy is 0, and occupancy is DEPTH, respectively.

Function
REQ-014 SHALL store entries in a circular buffer with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-015 SHALL compute enqueue count E as: 2 if i_enq_valid==2'b11 and o_enq_ready[1]; 1 if i_enq_valid[0] and o_enq_ready[0] and E is not 2; otherwise 0.
REQ-016 SHALL enqueue nothing for i_enq_valid==2'b10, and when only bundle0 fits, enqueue only bundle0.
REQ-017 SHALL derive o_enq_ready from the registered count only, never from same-cycle dequeue: o_enq_ready[0] = count<=DEPTH-1, o_enq_ready[1] = count<=DEPTH-2.
REQ-018 SHALL drive o_ins_valid as a thermometer of min(count,4): count 0 gives 4'b0000, count 1 gives 4'b0001, count 2 gives 4'b0011, count 3 gives 4'b0111, and count of 4 or more gives 4'b1111.
REQ-019 SHALL drive o_ins_bundlek = mem[(head+k) mod DEPTH] when o_ins_valid[k] is high, and all zeros otherwise.
REQ-020 SHALL make all o_ins_* outputs combinational from state, with no dependence on any same-cycle input.
REQ-021 SHALL compute dequeue count D as the number of leading consecutive ones of (i_disp_accept & o_ins_valid) starting at bit 0 (0 to 4), ignoring any bits after the first zero so that dispatch stays in order.
REQ-022 SHALL, on each edge without flush, advance head by D, write the E bundles at tail then tail+1, advance tail by E, and set count to count+E-D.
REQ-023 SHALL allow enqueue and dequeue in the same cycle.
REQ-024 SHALL never let count exceed DEPTH or go below 0.
REQ-025 SHALL, when i_flush is high at an edge, set head, tail and count to 0, ignoring E and D that cycle.
REQ-026 SHALL, when i_flush is high, leave o_enq_ready and o_ins_valid unaffected until the next edge.
REQ-027 SHALL drive o_empty as count==0 and o_full as count==DEPTH, both combinational from the registered count.

Reset
REQ-028 SHALL, while i_rst is high, asynchronously force head=0, tail=0, count=0 and every mem entry to zero.
REQ-029 SHALL, while i_rst is high, drive o_ins_valid=4'b0000, all o_ins_bundlek=0, o_enq_ready=2'b11, o_count=0, o_empty=1 and o_full=0.
REQ-030 SHALL, on reset assertion mid-operation, discard in-flight enqueue and dequeue, and accept the first enqueue on the first rising edge after i_rst deasserts.

Verification
REQ-031 SHALL pass this scenario: after reset, enqueue A,B (valid 2'b11), then C (valid 2'b01) -> o_count=3, o_ins_valid=4'b0111, bundles 0..2 are A,B,C and bundle3 is 0.
REQ-032 SHALL pass this scenario: with 4 entries A..D, i_disp_accept=4'b1011 -> D=2, the next cycle shows C,D in slots 0,1 and o_count=2.
REQ-033 SHALL pass this scenario: fill to count=7 (DEPTH=8) -> o_enq_ready=2'b01; enqueue with valid 2'b11 -> only bundle0 is written, count=8, o_full=1 and o_enq_ready=2'b00.
REQ-034 SHALL pass this scenario: at count=8, accept 4'b1111 and enqueue 2'b11 in the same cycle -> no enqueue occurs (ready was 0), and count=4.
REQ-035 SHALL pass this scenario: wrap-around, 20 cycles of enqueue 2, dequeue 2 -> FIFO order preserved across pointer wrap, and count stays constant.
REQ-036 SHALL pass this scenario: i_flush with count=5 together with enqueue and accept -> next cycle count=0, o_empty=1 and o_ins_valid=4'b0000.

Source files
------------

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order instruction queue, two enqueues and up to four dispatches per cycle
module dispatch_queue #(
  parameter int BWIDTH = 57,
  parameter int DEPTH  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic [BWIDTH-1:0]        i_enq_bundle0,
  input  logic [BWIDTH-1:0]        i_enq_bundle1,
  input  logic [1:0]               i_enq_valid,
  output logic [1:0]               o_enq_ready,
  output logic [BWIDTH-1:0]        o_ins_bundle0,
  output logic [BWIDTH-1:0]        o_ins_bundle1,
  output logic [BWIDTH-1:0]        o_ins_bundle2,
  output logic [BWIDTH-1:0]        o_ins_bundle3,
  output logic [3:0]               o_ins_valid,
  input  logic [3:0]               i_disp_accept,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [1:0]        e;
  logic [2:0]        d;
  logic [3:0]        m;
  logic [BWIDTH-1:0] ins [4];

  assign o_enq_ready = {count <= CW'(DEPTH - 2), count <= CW'(DEPTH - 1)};
  assign o_count     = count;
  assign o_empty     = count == '0;
  assign o_full      = count == CW'(DEPTH);

  // Enqueue/dequeue counts; dispatch stops at the first unaccepted slot to keep order
  always_comb begin
    e = (i_enq_valid == 2'b11 && o_enq_ready[1]) ? 2'd2 :
        (i_enq_valid[0] && o_enq_ready[0])       ? 2'd1 : 2'd0;
    o_ins_valid = (count >= CW'(4)) ? 4'b1111 :
                  (count == CW'(3)) ? 4'b0111 :
                  (count == CW'(2)) ? 4'b0011 :
                  (count == CW'(1)) ? 4'b0001 : 4'b0000;
    m = i_disp_accept & o_ins_valid;
    d = !m[0] ? 3'd0 : !m[1] ? 3'd1 : !m[2] ? 3'd2 : !m[3] ? 3'd3 : 3'd4;
  end

  for (genvar k = 0; k < 4; k++) begin : g_ins
    assign ins[k] = o_ins_valid[k] ? mem[head + AW'(k)] : '0;
  end

  assign o_ins_bundle0 = ins[0];
  assign o_ins_bundle1 = ins[1];
  assign o_ins_bundle2 = ins[2];
  assign o_ins_bundle3 = ins[3];

  // Pointer, occupancy and storage update; flush drops everything without touching storage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (e != 2'd0) mem[tail] <= i_enq_bundle0;
      if (e == 2'd2) mem[tail + AW'(1)] <= i_enq_bundle1;
      head  <= head + AW'(d);
      tail  <= tail + AW'(e);
      count <= count + CW'(e) - CW'(d);
    end
  end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: table vectors plus queue scoreboard for dispatch_queue
module tb_dispatch_queue;
  localparam int BW = 57;
  localparam int DEPTH = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_flush;
  logic [BW-1:0] i_enq_bundle0, i_enq_bundle1;
  logic [1:0]    i_enq_valid;
  logic [1:0]    o_enq_ready;
  logic [BW-1:0] o_ins_bundle0, o_ins_bundle1, o_ins_bundle2, o_ins_bundle3;
  logic [3:0]    o_ins_valid;
  logic [3:0]    i_disp_accept;
  logic [3:0]    o_count;
  logic          o_empty, o_full;

  dispatch_queue #(.BWIDTH(BW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_enq_bundle0(i_enq_bundle0), .i_enq_bundle1(i_enq_bundle1),
    .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready),
    .o_ins_bundle0(o_ins_bundle0), .o_ins_bundle1(o_ins_bundle1),
    .o_ins_bundle2(o_ins_bundle2), .o_ins_bundle3(o_ins_bundle3),
    .o_ins_valid(o_ins_valid), .i_disp_accept(i_disp_accept),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0] v;
    logic [3:0] acc;
    logic       fl;
    int         cnt;
    logic [1:0] rdy;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            seq = 0;
  logic [BW-1:0] mq [$];
  vec_t          tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] therm(input int n);
    return n >= 4 ? 4'hF : 4'((1 << n) - 1);
  endfunction

  task automatic check_all(input string tag);
    int            n;
    logic [BW-1:0] o [4];
    logic [1:0]    er;
    n = mq.size();
    o = '{o_ins_bundle0, o_ins_bundle1, o_ins_bundle2, o_ins_bundle3};
    er = {n <= DEPTH - 2, n <= DEPTH - 1};
    chk({tag, " count"}, 64'(o_count), 64'(n));
    chk({tag, " ins_valid"}, 64'(o_ins_valid), 64'(therm(n)));
    chk({tag, " enq_ready"}, 64'(o_enq_ready), 64'(er));
    chk({tag, " empty"}, 64'(o_empty), 64'(n == 0));
    chk({tag, " full"}, 64'(o_full), 64'(n == DEPTH));
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s bundle%0d", tag, k), 64'(o[k]), k < n ? 64'(mq[k]) : 64'(0));
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, " count"}, 64'(o_count), 64'(0));
    chk({tag, " ins_valid"}, 64'(o_ins_valid), 64'(0));
    chk({tag, " enq_ready"}, 64'(o_enq_ready), 64'(3));
    chk({tag, " empty"}, 64'(o_empty), 64'(1));
    chk({tag, " full"}, 64'(o_full), 64'(0));
    chk({tag, " bundles"}, 64'(o_ins_bundle0 | o_ins_bundle1 | o_ins_bundle2 | o_ins_bundle3), 64'(0));
  endtask

  task automatic step(input logic [1:0] v, input logic [3:0] acc, input logic fl, input string tag);
    int            n;
    int            e;
    int            d;
    logic [BW-1:0] x0, x1;
    n = mq.size();
    d = 0;
    x0 = {25'(seq), 32'($urandom())};
    x1 = {25'(seq + 1), 32'($urandom())};
    seq += 2;
    i_enq_valid = v;
    i_enq_bundle0 = x0;
    i_enq_bundle1 = x1;
    i_disp_accept = acc;
    i_flush = fl;
    e = (v == 2'b11 && n <= DEPTH - 2) ? 2 : (v[0] && n <= DEPTH - 1) ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      if (acc[k] && k < n) d++;
      else break;
    end
    #1;
    if (fl) begin
      chk({tag, " flush ins_valid hold"}, 64'(o_ins_valid), 64'(therm(n)));
      chk({tag, " flush ready hold"}, 64'(o_enq_ready), 64'({n <= DEPTH - 2, n <= DEPTH - 1}));
    end
    @(posedge i_clk);
    if (fl) mq.delete();
    else begin
      repeat (d) void'(mq.pop_front());
      if (e >= 1) mq.push_back(x0);
      if (e == 2) mq.push_back(x1);
    end
    #1;
    check_all(tag);
    i_enq_valid = 2'b00;
    i_disp_accept = 4'b0000;
    i_flush = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{2'b11, 4'b0000, 1'b0, 2, 2'b11};
    tbl[1]  = '{2'b01, 4'b0000, 1'b0, 3, 2'b11};
    tbl[2]  = '{2'b01, 4'b0000, 1'b0, 4, 2'b11};
    tbl[3]  = '{2'b00, 4'b1011, 1'b0, 2, 2'b11};
    tbl[4]  = '{2'b11, 4'b0000, 1'b0, 4, 2'b11};
    tbl[5]  = '{2'b11, 4'b0000, 1'b0, 6, 2'b11};
    tbl[6]  = '{2'b01, 4'b0000, 1'b0, 7, 2'b01};
    tbl[7]  = '{2'b11, 4'b0000, 1'b0, 8, 2'b00};
    tbl[8]  = '{2'b11, 4'b1111, 1'b0, 4, 2'b11};
    tbl[9]  = '{2'b10, 4'b0000, 1'b0, 4, 2'b11};
    tbl[10] = '{2'b01, 4'b0001, 1'b0, 4, 2'b11};
    tbl[11] = '{2'b00, 4'b0010, 1'b0, 4, 2'b11};
    tbl[12] = '{2'b11, 4'b1111, 1'b1, 0, 2'b11};

    i_rst = 1'b1;
    i_flush = 1'b0;
    i_enq_valid = 2'b00;
    i_disp_accept = 4'b0000;
    i_enq_bundle0 = '0;
    i_enq_bundle1 = '0;
    #8;
    reset_chk("reset");
    #4;
    i_rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].acc, tbl[i].fl, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d const count", i), 64'(o_count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d const ready", i), 64'(o_enq_ready), 64'(tbl[i].rdy));
    end

    step(2'b11, 4'b0000, 1'b0, "wrap fill0");
    step(2'b11, 4'b0000, 1'b0, "wrap fill1");
    for (int i = 0; i < 20; i++) begin
      step(2'b11, 4'b0011, 1'b0, $sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d const count", i), 64'(o_count), 64'(4));
    end

    step(2'b01, 4'b0000, 1'b0, "flush fill");
    chk("flush pre count", 64'(o_count), 64'(5));
    step(2'b11, 4'b1111, 1'b1, "flush");
    chk("flush const count", 64'(o_count), 64'(0));
    chk("flush const empty", 64'(o_empty), 64'(1));
    chk("flush const ins_valid", 64'(o_ins_valid), 64'(0));

    step(2'b11, 4'b0000, 1'b0, "midrst fill");
    #2;
    i_rst = 1'b1;
    i_enq_valid = 2'b11;
    i_disp_accept = 4'b1111;
    mq.delete();
    #1;
    reset_chk("midrst async");
    #8;
    reset_chk("midrst held");
    i_rst = 1'b0;
    i_enq_valid = 2'b00;
    i_disp_accept = 4'b0000;
    step(2'b01, 4'b0000, 1'b0, "post rst");
    chk("post rst const count", 64'(o_count), 64'(1));

    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(0, 30) == 0,
           $sformatf("rnd%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
